// File: rtl/button_input_port_pkg.sv
// Shared peripheral constants for the memory-mapped I/O block.
// Display and button register addresses plus debounce helpers.
package button_input_port_pkg;

  localparam logic [31:0] DISP_ADDR      = 32'h6000_0000;
  localparam logic [31:0] BTN_LEVEL_ADDR = 32'h7000_0000;
  localparam logic [31:0] BTN_EDGE_ADDR  = 32'h7000_0004;

  function automatic int unsigned cnt_width(
    input int unsigned cycles
  );
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_input_port_debounce_cell.sv
// One button bit: 2-flop synchroniser, stability counter, level.
// rise_o is high in the cycle whose clock edge makes stable_o go 1.
module debounce_cell
  import button_input_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          done;

  assign done     = (s2 != stable) && (cnt == LAST);
  assign rise_o   = done & s2;
  assign stable_o = stable;

  // bring the raw level into the clock domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
    end
  end

  // flip the level only after s2 disagrees for a full window
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt    <= '0;
    end else if (cnt == LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/button_input_port.sv
// Push-button input peripheral: debounced LEVEL and sticky
// press-event EDGE registers on the CPU load/store bus.
module button_input_port
  import button_input_port_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = BTN_LEVEL_ADDR
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  input  logic [NUM_BTN-1:0] btn_i
);

  localparam logic [31:0] LEVEL_ADDR = BASE_ADDR;
  localparam logic [31:0] EDGE_ADDR  = BASE_ADDR + 32'd4;

  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] clr;
  logic               lvl_rd;
  logic               edge_rd;
  logic               edge_wr;
  logic               unused_wdata;

  assign lvl_rd  = en_i && !we_i && (addr_i == LEVEL_ADDR);
  assign edge_rd = en_i && !we_i && (addr_i == EDGE_ADDR);
  assign edge_wr = en_i &&  we_i && (addr_i == EDGE_ADDR);
  assign clr     = edge_wr ? wdata_i[NUM_BTN-1:0] : '0;

  // only the low NUM_BTN data bits address event flags
  assign unused_wdata = ^wdata_i;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .btn_i   (btn_i[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i])
    );
  end

  // sticky press flags, write-1-to-clear; a new press beats a clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      press_q <= '0;
    end else begin
      press_q <= (press_q & ~clr) | rise;
    end
  end

  // one-cycle registered read port, zero when not reading
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else begin
      unique case (1'b1)
        lvl_rd:  rdata_o <= 32'(stable);
        edge_rd: rdata_o <= 32'(press_q);
        default: rdata_o <= '0;
      endcase
    end
  end

endmodule

// File: doc/button_input_port.md
Name: button_input_port

Overview:
- Memory-mapped input peripheral, the read-side counterpart of the write-only seven-segment display register.
- Samples NUM_BTN external push-buttons, synchronises and debounces them, and latches press events into a sticky capture register.
- The CPU load/store path reads button state and press events and clears events, using the same en_i/we_i/address/data bus style as the display register.

Parameters:
- NUM_BTN, 4, number of button inputs; 1..32.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes; minimum 2.
- BASE_ADDR, 32'h70000000, address of the LEVEL register; the EDGE register is at BASE_ADDR+4.

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- en_i  in  1  bus access valid this cycle
- we_i  in  1  1 = write, 0 = read (qualified by en_i)
- addr_i  in  32  byte address of the access
- wdata_i  in  32  write data
- rdata_o  out  32  registered read data
- btn_i  in  NUM_BTN  raw asynchronous button levels, active-high

Behaviour:
- Reset (async, rst_ni=0) clears all of the following to 0, and they stay 0 while rst_ni is low:
  - sync flops
  - debounce counters
  - stable levels
  - edge register
  - rdata_o
- Reset mid-debounce discards the partial count. Reset mid-read drives rdata_o to 0.
- Synchroniser: two flops per bit, btn_i -> s1 -> s2. Synchronisation adds 2 cycles of latency.
- Debounce, per bit, with counter width $clog2(DEBOUNCE_CYCLES):
  - If s2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Else: counter <= counter+1.
  - stable therefore flips exactly DEBOUNCE_CYCLES cycles after s2 first differs, if s2 holds.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count and never flips stable.
- Press event: stable transitions 0->1. This sets edge[i] in the same cycle that stable[i] becomes 1. Release (1->0) sets nothing.
- Read of LEVEL: en_i=1, we_i=0, addr_i==BASE_ADDR.
  - Next cycle rdata_o = {zero-extend, stable}.
- Read of EDGE: en_i=1, we_i=0, addr_i==BASE_ADDR+4.
  - Next cycle rdata_o = {zero-extend, edge}.
  - Reading does not clear the register.
- Any other cycle (no access, a write, or an unmapped address): next cycle rdata_o = 0. Read latency is exactly 1 cycle.
- Write to EDGE: en_i=1, we_i=1, addr_i==BASE_ADDR+4. This is write-1-to-clear: edge <= edge & ~wdata_i[NUM_BTN-1:0]. Upper wdata bits are ignored.
- Writes to LEVEL or to unmapped addresses are ignored, with no side effects.
- Same-cycle set and clear of one edge bit: set wins and the bit stays 1. Clearing other bits proceeds normally.
- Same-cycle read of EDGE and a press: rdata_o shows the pre-update value, and the new bit is visible on the next read.
- Address decode is an exact 32-bit compare. Low-order misaligned addresses do not alias.

Decomposition:
- Shared peripheral package holds:
  - the address constants: BTN_LEVEL_ADDR = 32'h70000000, BTN_EDGE_ADDR = 32'h70000004, alongside the display address 32'h60000000
  - a function computing the counter width from DEBOUNCE_CYCLES
- Sub-module debounce_cell: one bit containing the 2-flop synchroniser, counter, and stable level, with output stable_o plus a one-cycle rise_o pulse. It is instantiated NUM_BTN times via generate. The top level holds the edge register, address decode, and rdata_o register.

Test Plan:
- Reset with btn_i=4'b1111 asserted async mid-cycle -> rdata_o, LEVEL, and EDGE read 0 immediately. After release, LEVEL=0 until 2+DEBOUNCE_CYCLES cycles have elapsed.
- DEBOUNCE_CYCLES=4: raise btn_i[0] and hold -> LEVEL reads 32'h1 and EDGE reads 32'h1 from cycle 6 after the change, not earlier. Poll LEVEL every cycle to confirm the exact cycle.
- DEBOUNCE_CYCLES=4: pulse btn_i[1] high for 3 cycles, low, then high again for 3 cycles -> LEVEL and EDGE remain 0 throughout.
- Press btn 0 and btn 2 (EDGE=32'h5), then write 32'h1 to BASE_ADDR+4 -> EDGE reads 32'h4. Write 32'hFFFFFFFF -> EDGE reads 0. Write 32'h5 to BASE_ADDR -> LEVEL unchanged.
- Time a W1C of bit 3 in the same cycle as the debounced press of btn 3 -> EDGE[3]=1 afterwards.
- Read from 32'h70000008 and 32'h60000000 -> rdata_o=0 one cycle later. A back-to-back LEVEL read then EDGE read returns each value in consecutive cycles.
